mux16_stream_arbiter: RTL and testbench

- Registered 2-to-1 merge of two 16-bit valid/ready streams (channels a and b) onto one output stream.
- It is the opposite direction of the 16-bit demux: it carries an out_sel tag (0 = a, 1 = b), so a downstream DMux16 can re-split the stream losslessly.
- Round-robin arbitration, a one-entry output register and zero-bubble throughput.
- Sits between two producers and a shared 16-bit datapath or bus.

---
 rtl/mux16_pkg.sv | 15 +
 rtl/rr_arb2.sv | 20 ++
 rtl/mux16_stream_arbiter.sv | 76 +++++++
 tb/tb_mux16_stream_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux16_pkg.sv
// Shared constants for the 16-bit two-channel stream merge: default width,
// channel index encoding and holding-register state encoding.
package mux16_pkg;

    localparam int DATA_W_DFLT = 16;

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant, purely combinational.
// On contention the requester that was not granted last time wins.
module rr_arb2
    import mux16_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req[0] && req[1]) begin
            grant = (last == CH_A) ? 2'b10 : 2'b01;
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/mux16_stream_arbiter.sv
// Round-robin merge of two valid/ready streams into one registered, tagged output.
// Optional out_parity port when MUX16_STREAM_PARITY_EN is defined.
//
// state    | meaning
// ST_EMPTY | holding register empty, out_valid = 0
// ST_FULL  | holding register holds a word, out_valid = 1
module mux16_stream_arbiter
    import mux16_pkg::*;
#(
    parameter int DATA_W     = mux16_pkg::DATA_W_DFLT,
    parameter bit RESET_LAST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_valid,
    output logic              b_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sel,
`ifdef MUX16_STREAM_PARITY_EN
    output logic              out_parity,
`endif
    output logic              out_valid,
    input  logic              out_ready
);

    state_t      state;
    logic        last_grant;
    logic [1:0]  grant;
    logic        can_load;
    logic        load;

    rr_arb2 u_arb (
        .req   ({b_valid, a_valid}),
        .last  (last_grant),
        .grant (grant)
    );

    assign out_valid = (state == ST_FULL);
    assign can_load  = (state == ST_EMPTY) | (out_valid & out_ready);

    // Ready is also held low while reset is asserted so nothing is accepted then.
    assign a_ready = rst_n & can_load & grant[0];
    assign b_ready = rst_n & can_load & grant[1];
    assign load    = (a_valid & a_ready) | (b_valid & b_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            out_data   <= '0;
            out_sel    <= CH_A;
            last_grant <= RESET_LAST;
        end else if (load) begin
            state      <= ST_FULL;
            out_data   <= grant[1] ? b_data : a_data;
            out_sel    <= grant[1] ? CH_B : CH_A;
            last_grant <= grant[1] ? CH_B : CH_A;
        end else if (out_valid && out_ready) begin
            state <= ST_EMPTY;
        end
    end

`ifdef MUX16_STREAM_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_parity <= 1'b0;
        end else if (load) begin
            out_parity <= grant[1] ? ^b_data : ^a_data;
        end
    end
`endif

endmodule

// File: tb/tb_mux16_stream_arbiter.sv
// Self-checking bench for mux16_stream_arbiter: directed scenarios plus a
// randomized run against a cycle-level behavioural model and per-channel queues.
module tb_mux16_stream_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] a_data = '0;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [15:0] b_data = '0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [15:0] out_data;
    logic        out_sel;
    logic        out_valid;
    logic        out_ready = 1'b0;
`ifdef MUX16_STREAM_PARITY_EN
    logic        out_parity;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux16_stream_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_data    (a_data),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .b_data    (b_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
`ifdef MUX16_STREAM_PARITY_EN
        .out_parity(out_parity),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_valid = 1'b1;
        b_valid = 1'b1;
        #3;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || out_sel !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b d=%h s=%b want v=0 d=0000 s=0", out_valid, out_data, out_sel);
        end
        checks++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got a=%b b=%b want 0 0", a_ready, b_ready);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        a_data = 16'h1111; b_data = 16'h2222;
        a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL first_grant got a=%b b=%b want a=1 b=0", a_ready, b_ready);
        end
        tick();
        a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h1111) begin
            errors++;
            $display("FAIL pre_reset_load got v=%b d=%h want v=1 d=1111", out_valid, out_data);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || out_sel !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got v=%b d=%h s=%b want v=0 d=0000 s=0", out_valid, out_data, out_sel);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_partial_output got v=%b want 0", out_valid);
        end
        a_valid = 1'b1; b_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL grant_after_rereset got a=%b b=%b want a=1 b=0", a_ready, b_ready);
        end
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        a_data = 16'h091E; a_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_ready got a=%b b=%b want a=1 b=0", a_ready, b_ready);
        end
        tick();
        a_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h091E || out_sel !== 1'b0 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_out got v=%b d=%h s=%b br=%b want v=1 d=091e s=0 br=0",
                     out_valid, out_data, out_sel, b_ready);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [15:0] exp_d [3];
        logic        exp_s [3];
        exp_d[0] = 16'h0D65; exp_s[0] = 1'b0;
        exp_d[1] = 16'h15BE; exp_s[1] = 1'b1;
        exp_d[2] = 16'h0D65; exp_s[2] = 1'b0;
        do_reset();
        a_data = 16'h0D65; b_data = 16'h15BE;
        a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_sel !== exp_s[i]) begin
                errors++;
                $display("FAIL rr_word%0d got v=%b d=%h s=%b want v=1 d=%h s=%b",
                         i, out_valid, out_data, out_sel, exp_d[i], exp_s[i]);
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        b_data = 16'h2103; b_valid = 1'b1; out_ready = 1'b0;
        tick();
        b_valid = 1'b0;
        a_data = 16'hA5C3; a_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'h2103 || out_sel !== 1'b1 || a_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b d=%h s=%b ar=%b want v=1 d=2103 s=1 ar=0",
                         i, out_valid, out_data, out_sel, a_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready got ar=%b want 1", a_ready);
        end
        tick();
        a_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hA5C3 || out_sel !== 1'b0) begin
            errors++;
            $display("FAIL bp_release_word got v=%b d=%h s=%b want v=1 d=a5c3 s=0", out_valid, out_data, out_sel);
        end
        tick();
    endtask

    task automatic test_drain();
        do_reset();
        a_data = 16'h4070; a_valid = 1'b1; out_ready = 1'b1;
        tick();
        a_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h4070) begin
            errors++;
            $display("FAIL drain_full got v=%b d=%h want v=1 d=4070", out_valid, out_data);
        end
        tick();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h4070 || out_sel !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty got v=%b d=%h s=%b want v=0 d=4070 s=0", out_valid, out_data, out_sel);
        end
    endtask

`ifdef MUX16_STREAM_PARITY_EN
    task automatic test_parity();
        do_reset();
        checks++;
        if (out_parity !== 1'b0) begin
            errors++;
            $display("FAIL parity_reset got %b want 0", out_parity);
        end
        out_ready = 1'b1;
        a_data = 16'h0007; a_valid = 1'b1;
        tick();
        a_data = 16'h0003;
        checks++;
        if (out_parity !== 1'b1) begin
            errors++;
            $display("FAIL parity_0007 got %b want 1", out_parity);
        end
        tick();
        a_valid = 1'b0;
        checks++;
        if (out_parity !== 1'b0) begin
            errors++;
            $display("FAIL parity_0003 got %b want 0", out_parity);
        end
        tick();
    endtask
`endif

    // Model: one-word buffer that may accept a new word whenever it is empty or
    // being emptied; contention goes to the channel not granted most recently.
    task automatic test_random();
        logic [15:0] q_a [$];
        logic [15:0] q_b [$];
        logic        m_full = 1'b0;
        logic [15:0] m_data = '0;
        logic        m_sel = 1'b0;
        logic        m_last = 1'b1;
        logic        acc_a = 1'b0, acc_b = 1'b0;
        logic        free, ga, gb;
        logic [15:0] w;
        int          words_out = 0;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            bit draining;
            draining = (cyc >= 560);
            if (!a_valid || acc_a) begin
                a_valid = !draining && ($urandom_range(0, 99) < 60);
                if (a_valid) begin a_data = 16'($urandom); q_a.push_back(a_data); end
            end
            if (!b_valid || acc_b) begin
                b_valid = !draining && ($urandom_range(0, 99) < 60);
                if (b_valid) begin b_data = 16'($urandom); q_b.push_back(b_data); end
            end
            out_ready = draining || ($urandom_range(0, 99) < 70);
            @(negedge clk);
            free = !m_full || out_ready;
            ga = free && a_valid && (!b_valid || m_last == 1'b1);
            gb = free && b_valid && (!a_valid || m_last == 1'b0);
            checks++;
            if (a_ready !== ga || b_ready !== gb || out_valid !== m_full) begin
                errors++;
                $display("FAIL rand_ctrl cyc%0d got ar=%b br=%b v=%b want ar=%b br=%b v=%b",
                         cyc, a_ready, b_ready, out_valid, ga, gb, m_full);
            end
            if (m_full) begin
                checks++;
                if (out_data !== m_data || out_sel !== m_sel) begin
                    errors++;
                    $display("FAIL rand_word cyc%0d got d=%h s=%b want d=%h s=%b",
                             cyc, out_data, out_sel, m_data, m_sel);
                end
                if (out_ready) begin
                    checks++;
                    if (m_sel == 1'b0 ? q_a.size() == 0 : q_b.size() == 0) begin
                        errors++;
                        $display("FAIL rand_order cyc%0d got word %h on ch%0d want none pending", cyc, out_data, m_sel);
                    end else begin
                        w = (m_sel == 1'b0) ? q_a.pop_front() : q_b.pop_front();
                        words_out++;
                        if (out_data !== w) begin
                            errors++;
                            $display("FAIL rand_order cyc%0d got %h want %h", cyc, out_data, w);
                        end
                    end
                end
            end
            acc_a = ga;
            acc_b = gb;
            if (ga || gb) begin
                m_full = 1'b1;
                m_data = ga ? a_data : b_data;
                m_sel  = gb;
                m_last = gb;
            end else if (m_full && out_ready) begin
                m_full = 1'b0;
            end
            tick();
        end
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0 || out_valid !== 1'b0 || words_out < 100) begin
            errors++;
            $display("FAIL rand_drain got qa=%0d qb=%0d v=%b n=%0d want qa=0 qb=0 v=0 n>=100",
                     q_a.size(), q_b.size(), out_valid, words_out);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_drain();
`ifdef MUX16_STREAM_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
